// File: rtl/dispatch_credit_ctrl.sv
// Credit-based admission control for a dual-uOP dispatch bundle into the ALU/MDU/LSU reservation stations.
// Tracks free RS entries, gates dispatch, and counts stall cycles by cause.
module dispatch_credit_ctrl #(
  parameter int ALU_DEPTH = 8,
  parameter int MDU_DEPTH = 4,
  parameter int LSU_DEPTH = 8,
  parameter int CNT_W     = 4,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              bundle_valid,
  input  logic [1:0]        alu_need,
  input  logic              mdu_need,
  input  logic [1:0]        lsu_need,
  input  logic              rob_ready,
  input  logic [1:0]        alu_free,
  input  logic              mdu_free,
  input  logic [1:0]        lsu_free,
  output logic              dispatch_fire,
  output logic              pause_req,
  output logic [CNT_W-1:0]  alu_credits,
  output logic [CNT_W-1:0]  mdu_credits,
  output logic [CNT_W-1:0]  lsu_credits,
  output logic [PERF_W-1:0] stall_rob_cnt,
  output logic [PERF_W-1:0] stall_rs_cnt,
  output logic              credit_err
);

  localparam logic [CNT_W-1:0]  ALU_FULL = CNT_W'(ALU_DEPTH);
  localparam logic [CNT_W-1:0]  MDU_FULL = CNT_W'(MDU_DEPTH);
  localparam logic [CNT_W-1:0]  LSU_FULL = CNT_W'(LSU_DEPTH);
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  r_alu_cred;
  logic [CNT_W-1:0]  r_mdu_cred;
  logic [CNT_W-1:0]  r_lsu_cred;
  logic [PERF_W-1:0] r_stall_rob;
  logic [PERF_W-1:0] r_stall_rs;
  logic              r_err;

  logic              w_rs_ok;
  logic              w_fire;
  logic              w_pause;
  logic              w_rob_stall;
  logic              w_rs_stall;
  logic [1:0]        w_alu_take;
  logic [1:0]        w_mdu_take;
  logic [1:0]        w_lsu_take;
  logic [CNT_W:0]    w_alu_nx;
  logic [CNT_W:0]    w_mdu_nx;
  logic [CNT_W:0]    w_lsu_nx;

  // Returns {error, saturated credit}; the sum is formed one bit wider so overflow is visible.
  function automatic logic [CNT_W:0] f_next(input logic [CNT_W-1:0] cred,
                                            input logic [1:0]       take,
                                            input logic [1:0]       give,
                                            input logic [CNT_W-1:0] full);
    logic [CNT_W:0] sum;
    logic [CNT_W:0] take_w;
    logic [CNT_W:0] res;
    logic           err;
    sum    = {1'b0, cred} + {{(CNT_W-1){1'b0}}, give};
    take_w = {{(CNT_W-1){1'b0}}, take};
    err    = 1'b0;
    if (sum < take_w) begin
      res = '0;
      err = 1'b1;
    end else begin
      res = sum - take_w;
      if (res > {1'b0, full}) begin
        res = {1'b0, full};
        err = 1'b1;
      end
    end
    return {err, res[CNT_W-1:0]};
  endfunction

  assign w_rs_ok = (r_alu_cred >= {{(CNT_W-2){1'b0}}, alu_need}) &
                   (r_mdu_cred >= {{(CNT_W-1){1'b0}}, mdu_need}) &
                   (r_lsu_cred >= {{(CNT_W-2){1'b0}}, lsu_need});

  assign w_fire      = bundle_valid & rob_ready & w_rs_ok & ~flush;
  assign w_pause     = bundle_valid & ~flush & ~(rob_ready & w_rs_ok);
  assign w_rob_stall = bundle_valid & ~flush & ~rob_ready;
  assign w_rs_stall  = bundle_valid & ~flush & rob_ready & ~w_rs_ok;

  assign w_alu_take = w_fire ? alu_need : 2'd0;
  assign w_mdu_take = {1'b0, w_fire & mdu_need};
  assign w_lsu_take = w_fire ? lsu_need : 2'd0;

  assign w_alu_nx = f_next(r_alu_cred, w_alu_take, alu_free, ALU_FULL);
  assign w_mdu_nx = f_next(r_mdu_cred, w_mdu_take, {1'b0, mdu_free}, MDU_FULL);
  assign w_lsu_nx = f_next(r_lsu_cred, w_lsu_take, lsu_free, LSU_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_cred  <= ALU_FULL;
      r_mdu_cred  <= MDU_FULL;
      r_lsu_cred  <= LSU_FULL;
      r_stall_rob <= '0;
      r_stall_rs  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (flush) begin
        r_alu_cred <= ALU_FULL;
        r_mdu_cred <= MDU_FULL;
        r_lsu_cred <= LSU_FULL;
      end else begin
        r_alu_cred <= w_alu_nx[CNT_W-1:0];
        r_mdu_cred <= w_mdu_nx[CNT_W-1:0];
        r_lsu_cred <= w_lsu_nx[CNT_W-1:0];
        if (w_alu_nx[CNT_W] | w_mdu_nx[CNT_W] | w_lsu_nx[CNT_W]) begin
          r_err <= 1'b1;
        end
      end
      if (w_rob_stall && (r_stall_rob != '1)) begin
        r_stall_rob <= r_stall_rob + PERF_ONE;
      end
      if (w_rs_stall && (r_stall_rs != '1)) begin
        r_stall_rs <= r_stall_rs + PERF_ONE;
      end
    end
  end

  // Combinational handshakes are forced low while reset is held.
  assign dispatch_fire = rst_n & w_fire;
  assign pause_req     = rst_n & w_pause;
  assign alu_credits   = r_alu_cred;
  assign mdu_credits   = r_mdu_cred;
  assign lsu_credits   = r_lsu_cred;
  assign stall_rob_cnt = r_stall_rob;
  assign stall_rs_cnt  = r_stall_rs;
  assign credit_err    = r_err;

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Bench for dispatch_credit_ctrl: directed vector table, reset-mid-operation sequence,
// and a randomized run against an integer-arithmetic reference model.
module tb_dispatch_credit_ctrl;

  localparam int ALU_D  = 8;
  localparam int MDU_D  = 4;
  localparam int LSU_D  = 8;
  localparam int PERF_W = 6;
  localparam int PMAX   = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, bundle_valid, mdu_need, rob_ready, mdu_free;
  logic [1:0] alu_need, lsu_need, alu_free, lsu_free;
  logic dispatch_fire, pause_req, credit_err;
  logic [3:0] alu_credits, mdu_credits, lsu_credits;
  logic [PERF_W-1:0] stall_rob_cnt, stall_rs_cnt;

  always #5 clk = ~clk;

  dispatch_credit_ctrl #(
    .ALU_DEPTH(ALU_D), .MDU_DEPTH(MDU_D), .LSU_DEPTH(LSU_D), .CNT_W(4), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bundle_valid(bundle_valid),
    .alu_need(alu_need), .mdu_need(mdu_need), .lsu_need(lsu_need), .rob_ready(rob_ready),
    .alu_free(alu_free), .mdu_free(mdu_free), .lsu_free(lsu_free),
    .dispatch_fire(dispatch_fire), .pause_req(pause_req),
    .alu_credits(alu_credits), .mdu_credits(mdu_credits), .lsu_credits(lsu_credits),
    .stall_rob_cnt(stall_rob_cnt), .stall_rs_cnt(stall_rs_cnt), .credit_err(credit_err)
  );

  typedef struct {
    int fl, bv, an, mn, ln, rob, af, mf, lf;
    int e_fire, e_pause, e_alu, e_mdu, e_lsu, e_srob, e_srs, e_err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int m_alu, m_mdu, m_lsu, m_srob, m_srs, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int fl, bv, an, mn, ln, rob, af, mf, lf);
    flush = 1'(fl); bundle_valid = 1'(bv); alu_need = 2'(an); mdu_need = 1'(mn);
    lsu_need = 2'(ln); rob_ready = 1'(rob); alu_free = 2'(af); mdu_free = 1'(mf);
    lsu_free = 2'(lf);
  endtask

  task automatic chk_regs(input string tag, input int a, m, l, sr, ss, e);
    chk({tag, " alu_credits"}, 32'(alu_credits), a);
    chk({tag, " mdu_credits"}, 32'(mdu_credits), m);
    chk({tag, " lsu_credits"}, 32'(lsu_credits), l);
    chk({tag, " stall_rob_cnt"}, 32'(stall_rob_cnt), sr);
    chk({tag, " stall_rs_cnt"}, 32'(stall_rs_cnt), ss);
    chk({tag, " credit_err"}, 32'(credit_err), e);
  endtask

  function automatic vec_t mk(int fl, bv, an, mn, ln, rob, af, mf, lf,
                              int fire, pause, a, m, l, sr, ss, e);
    vec_t v;
    v.fl = fl; v.bv = bv; v.an = an; v.mn = mn; v.ln = ln; v.rob = rob;
    v.af = af; v.mf = mf; v.lf = lf;
    v.e_fire = fire; v.e_pause = pause; v.e_alu = a; v.e_mdu = m; v.e_lsu = l;
    v.e_srob = sr; v.e_srs = ss; v.e_err = e;
    return v;
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    // idle, fill the ALU, then stall on RS credits
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0, 8,4,8, 0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1,0,0,0, 1,0, 6,4,8, 0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1,0,0,0, 1,0, 4,4,8, 0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1,0,0,0, 1,0, 2,4,8, 0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1,0,0,0, 1,0, 0,4,8, 0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1,0,0,0, 0,1, 0,4,8, 0,1,0));
    // free/alloc overlap: freed credit is not usable in the same cycle
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0, 0,0, 1,4,8, 0,1,0));
    tbl.push_back(mk(0,1,2,0,0,1,2,0,0, 0,1, 3,4,8, 0,2,0));
    tbl.push_back(mk(0,1,2,0,0,1,0,0,0, 1,0, 1,4,8, 0,2,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0, 8,4,8, 0,2,0));
    // ROB stall takes attribution priority over RS
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,1,0,0,2,0,0,0,0, 0,1, 8,4,8, k,2,0));
    // drain to 2/1/3, then flush with competing frees and a valid bundle
    tbl.push_back(mk(0,1,2,1,2,1,0,0,0, 1,0, 6,3,6, 5,2,0));
    tbl.push_back(mk(0,1,2,1,2,1,0,0,0, 1,0, 4,2,4, 5,2,0));
    tbl.push_back(mk(0,1,2,1,1,1,0,0,0, 1,0, 2,1,3, 5,2,0));
    tbl.push_back(mk(1,1,2,0,0,1,2,0,0, 0,0, 8,4,8, 5,2,0));
    // overflow at full credits sets the sticky error and saturates
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0, 0,0, 8,4,8, 5,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0, 8,4,8, 5,2,1));
    tbl.push_back(mk(0,1,0,1,0,1,0,1,0, 1,0, 8,4,8, 5,2,1));

    // reset with a valid bundle presented: handshakes must stay low
    rst_n = 1'b0;
    drive(0,1,0,0,0,1,0,0,0);
    #12;
    chk("reset dispatch_fire", 32'(dispatch_fire), 0);
    chk("reset pause_req", 32'(pause_req), 0);
    chk_regs("reset", 8, 4, 8, 0, 0, 0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0,0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle pause_req", 32'(pause_req), 0);
      @(posedge clk);
      #1;
      chk_regs("idle", 8, 4, 8, 0, 0, 0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].bv, tbl[i].an, tbl[i].mn, tbl[i].ln, tbl[i].rob,
            tbl[i].af, tbl[i].mf, tbl[i].lf);
      #1;
      chk($sformatf("vec%0d dispatch_fire", i), 32'(dispatch_fire), tbl[i].e_fire);
      chk($sformatf("vec%0d pause_req", i), 32'(pause_req), tbl[i].e_pause);
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i), tbl[i].e_alu, tbl[i].e_mdu, tbl[i].e_lsu,
               tbl[i].e_srob, tbl[i].e_srs, tbl[i].e_err);
    end

    // reset asserted mid-cycle: credits restored at once, pending frees dropped
    @(negedge clk);
    drive(0,1,2,1,0,1,0,0,0);
    @(posedge clk);
    #1;
    chk("pre-reset alu_credits", 32'(alu_credits), 6);
    chk("pre-reset mdu_credits", 32'(mdu_credits), 3);
    @(negedge clk);
    drive(0,1,2,0,0,1,2,1,0);
    #1;
    chk("pre-reset dispatch_fire", 32'(dispatch_fire), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset dispatch_fire", 32'(dispatch_fire), 0);
    chk("midreset pause_req", 32'(pause_req), 0);
    chk_regs("midreset", 8, 4, 8, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_regs("midreset hold", 8, 4, 8, 0, 0, 0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0,0);
    rst_n = 1'b1;

    m_alu = ALU_D; m_mdu = MDU_D; m_lsu = LSU_D;
    m_srob = 0; m_srs = 0; m_err = 0;

    for (int c = 0; c < 1500; c++) begin
      int fl, bv, an, mn, ln, rob, af, mf, lf;
      int rs_ok, e_fire, e_pause, na, nm, nl;
      @(negedge clk);
      fl  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      bv  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      an  = $urandom_range(0, 2);
      mn  = $urandom_range(0, 1);
      ln  = $urandom_range(0, 2);
      rob = ($urandom_range(0, 4) != 0) ? 1 : 0;
      af  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, min2(2, ALU_D - m_alu));
      mf  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, min2(1, MDU_D - m_mdu));
      lf  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, min2(2, LSU_D - m_lsu));
      if ($urandom_range(0, 199) == 0) af = $urandom_range(0, 2);
      drive(fl, bv, an, mn, ln, rob, af, mf, lf);

      rs_ok   = (m_alu >= an && m_mdu >= mn && m_lsu >= ln) ? 1 : 0;
      e_fire  = (bv && rob && rs_ok && !fl) ? 1 : 0;
      e_pause = (bv && !fl && !(rob && rs_ok)) ? 1 : 0;
      #1;
      chk("rand dispatch_fire", 32'(dispatch_fire), e_fire);
      chk("rand pause_req", 32'(pause_req), e_pause);

      if (fl) begin
        m_alu = ALU_D; m_mdu = MDU_D; m_lsu = LSU_D;
      end else begin
        na = m_alu - (e_fire ? an : 0) + af;
        nm = m_mdu - (e_fire ? mn : 0) + mf;
        nl = m_lsu - (e_fire ? ln : 0) + lf;
        if (na < 0 || na > ALU_D || nm < 0 || nm > MDU_D || nl < 0 || nl > LSU_D) m_err = 1;
        m_alu = (na < 0) ? 0 : ((na > ALU_D) ? ALU_D : na);
        m_mdu = (nm < 0) ? 0 : ((nm > MDU_D) ? MDU_D : nm);
        m_lsu = (nl < 0) ? 0 : ((nl > LSU_D) ? LSU_D : nl);
      end
      if (bv && !fl && !rob) m_srob = min2(m_srob + 1, PMAX);
      else if (bv && !fl && !rs_ok) m_srs = min2(m_srs + 1, PMAX);

      @(posedge clk);
      #1;
      chk_regs("rand", m_alu, m_mdu, m_lsu, m_srob, m_srs, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_credit_ctrl.md
Name: dispatch_credit_ctrl

Overview:
- Credit-based admission controller between rename/decode and the dispatch stage.
- Tracks free entries in the ALU, MDU and LSU reservation-station queues.
- Decides each cycle whether the current dual-uOP bundle may dispatch. Raises the pause request when any target queue lacks room or the ROB is not ready.
- Returns credits as queues issue entries, restores all credits on pipeline flush, and keeps stall statistics for performance tuning.

Parameters:
- ALU_DEPTH, 8, ALU RS entries (≥2)
- MDU_DEPTH, 4, MDU RS entries (≥1); one MDU entry holds a full hi/lo pair
- LSU_DEPTH, 8, LSU RS entries (≥2)
- CNT_W, 4, credit counter width; must hold each DEPTH
- PERF_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; all RS queues emptied this cycle
- bundle_valid  in  1  bundle at dispatch holds ≥1 valid uOP
- alu_need  in  2  ALU entries the bundle needs (0..2)
- mdu_need  in  1  MDU entries needed (0..1)
- lsu_need  in  2  LSU entries needed (0..2)
- rob_ready  in  1  ROB can accept the bundle
- alu_free  in  2  ALU entries released this cycle (0..2)
- mdu_free  in  1  MDU entry released this cycle
- lsu_free  in  2  LSU entries released this cycle (0..2)
- dispatch_fire  out  1  bundle is accepted this cycle; RS write enables are qualified by it
- pause_req  out  1  stall the front end
- alu_credits  out  CNT_W  free ALU entries (registered)
- mdu_credits  out  CNT_W  free MDU entries (registered)
- lsu_credits  out  CNT_W  free LSU entries (registered)
- stall_rob_cnt  out  PERF_W  cycles stalled on ROB
- stall_rs_cnt  out  PERF_W  cycles stalled on RS credits
- credit_err  out  1  sticky: underflow or overflow detected

Behaviour:
- Reset (async, rst_n=0):
  - alu_credits=ALU_DEPTH, mdu_credits=MDU_DEPTH, lsu_credits=LSU_DEPTH.
  - Both stall counters = 0; credit_err = 0.
  - dispatch_fire=0 and pause_req=0, because both outputs are gated by rst_n.
- RS readiness: rs_ok = (alu_credits ≥ alu_need) & (mdu_credits ≥ mdu_need) & (lsu_credits ≥ lsu_need). Compare against registered credits only.
- Frees are not bypassed. A credit returned in cycle N is usable in cycle N+1.
- dispatch_fire = bundle_valid & rob_ready & rs_ok & ~flush. Combinational, zero latency.
- pause_req = bundle_valid & ~flush & ~(rob_ready & rs_ok).
- Credit update when flush=0: credit' = credit − (dispatch_fire ? need : 0) + free.
  - Compute at CNT_W+1 bits.
  - Simultaneous allocate and free in one cycle are both applied.
- Flush:
  - Next cycle all credits = DEPTH.
  - Frees and needs in the flush cycle are ignored.
  - Flush wins over every other event.
- Error detection:
  - If the computed credit' < 0 or > DEPTH, set credit_err=1 and saturate the credit at 0 or DEPTH respectively.
  - credit_err clears only on reset.
- Performance counters (saturate at all-ones, never wrap):
  - stall_rob_cnt increments when bundle_valid & ~flush & ~rob_ready.
  - stall_rs_cnt increments when bundle_valid & ~flush & rob_ready & ~rs_ok.
  - The two increments are mutually exclusive; ROB stall takes attribution priority.
  - Flush does not clear the counters.
- bundle_valid=0: no fire, no pause. Frees still return credits.
- Reset asserted mid-operation restores full credits immediately. In-flight frees are dropped.

Test Plan:
- Reset then idle: credits 8/4/8, counters 0, pause_req=0 for 10 cycles.
- Fill ALU: alu_need=2 with rob_ready=1 for 4 cycles → fire each cycle, alu_credits 8→6→4→2→0. Next bundle → pause_req=1, stall_rs_cnt=1.
- Free/alloc overlap: alu_credits=1, alu_need=2, alu_free=2 → no fire this cycle (no bypass), credits become 3. Next cycle fires, credits become 1.
- ROB stall priority: credits full, rob_ready=0 and lsu_need=2 for 5 cycles → stall_rob_cnt=5, stall_rs_cnt=0, lsu_credits stays 8.
- Flush: credits 2/1/3 with flush=1, alu_free=2 and bundle_valid=1 → dispatch_fire=0, pause_req=0. Next cycle credits 8/4/8 and counters unchanged.
- Error: at full credits, alu_free=1 → credit_err=1 and alu_credits stays 8. Flag holds until rst_n=0.
